apb_master_bridge: RTL
======================

# apb_master_bridge

Synthesizable APB master sitting directly upstream of the `apb_if` slave port. It accepts single transfers on a valid/ready request channel, runs each as one APB SETUP/ACCESS sequence on the APB signal set, and returns read data and error status on a valid/ready response channel. A programmable timeout terminates accesses whose slave never asserts `pready`.

## Interface
- `AW`, 32, address width
- `DW`, 32, data width
- `SW`, DW/8, byte select width
- `TO`, 256, ACCESS-phase timeout in cycles; 0 disables the timeout
- `clk`  input  1  clock
- `rst`  input  1  reset, asynchronous, active-high
- `req_vld`  input  1  request valid
- `req_rdy`  output  1  request ready
- `req_wen`  input  1  write enable (1 write, 0 read)
- `req_adr`  input  AW  address
- `req_sel`  input  SW  byte select
- `req_dtw`  input  DW  write data
- `rsp_vld`  output  1  response valid
- `rsp_rdy`  input  1  response ready
- `rsp_dtr`  output  DW  read data
- `rsp_err`  output  1  error (slave error or timeout)
- `pstrb`  output  1  APB transfer strobe (select)
- `penable`  output  1  APB transfer enable
- `pwrite`  output  1  APB write enable
- `paddr`  output  AW  APB address
- `psel`  output  SW  APB byte select
- `pwdata`  output  DW  APB write data
- `prdata`  input  DW  APB read data
- `pready`  input  1  APB transfer ready
- `pslverr`  input  1  APB slave error

## Operation
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE: `req_rdy`=1. On `req_vld`&`req_rdy` at a posedge: register `req_wen/adr/sel/dtw` onto `pwrite/paddr/psel/pwdata`, go to SETUP.
- SETUP: `pstrb`=1, `penable`=0, `req_rdy`=0; unconditionally go to ACCESS.
- ACCESS: `pstrb`=1, `penable`=1. At the posedge where `pready`=1: capture `prdata` into `rsp_dtr` (reads; writes load 0), `pslverr` into `rsp_err`, go to RESP.
- Timeout (TO>0): a wait counter clears on entry to ACCESS and increments for each ACCESS cycle with `pready`=0. At the posedge where the count reaches TO with `pready` still 0, go to RESP with `rsp_err`=1 and `rsp_dtr`=0. Counter width is $clog2(TO+1). A `pready`=1 on the same edge takes priority over the timeout.
- RESP: `pstrb`=0, `penable`=0, `rsp_vld`=1. `rsp_dtr` and `rsp_err` are held stable until `rsp_rdy`=1 at a posedge, then go to IDLE.
- `pwrite/paddr/psel/pwdata` stay constant from SETUP through ACCESS. They hold their last values in RESP and IDLE until the next acceptance.
- One outstanding transfer only. No pipelining.

## Timing
- Reset (asynchronous, any state): FSM goes to IDLE. All outputs are 0 (`req_rdy` is 0 while `rst` is high and 1 in the first cycle after deassertion). The wait counter clears.
- Reset mid-transfer aborts it. No response is produced and `pstrb`/`penable` drop immediately.
- Zero-wait-state latency: request accepted at edge 0, SETUP in cycle 1, ACCESS in cycle 2 (`pready` sampled at edge 2), `rsp_vld` high in cycle 3.
- N wait states add N cycles to the latency.
- Minimum request-to-request spacing is 4 cycles (IDLE, SETUP, ACCESS, RESP).
- `pready` and `pslverr` are ignored outside ACCESS. `pslverr` counts only together with `pready`=1.
- `rsp_rdy` held high: RESP lasts exactly 1 cycle. `rsp_rdy` low: RESP stalls indefinitely and `req_rdy` stays 0.
- `req_vld` while not in IDLE: the request is not accepted and the requester holds it.

## Test plan
- Reset then read, `req_adr`=0x10, slave `pready`=1 immediately, `prdata`=0xDEADBEEF -> `pstrb` high in cycles 1-2, `penable` high in cycle 2 only, `rsp_vld` in cycle 3 with `rsp_dtr`=0xDEADBEEF and `rsp_err`=0.
- Write, `req_adr`=0x20, `req_sel`=4'b0011, `req_dtw`=0x12345678, slave inserts 3 wait states -> `paddr/psel/pwdata/pwrite`=1 are stable for 5 cycles, `rsp_vld` in cycle 6 with `rsp_dtr`=0.
- Read with `pslverr`=1 together with `pready` -> `rsp_err`=1 and `rsp_dtr`=`prdata`. Next request accepted only after `rsp_rdy`.
- TO=4, slave never asserts `pready` -> ACCESS lasts 4 cycles, then `pstrb`=`penable`=0, `rsp_vld`=1, `rsp_err`=1, `rsp_dtr`=0. Repeat with `pready` arriving on the 4th ACCESS edge -> normal response with `rsp_err`=0.
- `rsp_rdy` held low for 5 cycles with `req_vld` held high -> `rsp_*` stable, `req_rdy`=0 throughout, second request accepted the cycle after the `rsp_rdy` handshake.
- Assert `rst` in the middle of ACCESS -> all outputs 0 immediately with no response. After release, a fresh read completes normally.

Source files
------------

// File: rtl/apb_master_bridge_if.sv
// Signal bundle between a request/response client, the APB master bridge and an APB slave.
// The master modport is the bridge's view; the slave modport is the environment's view.
interface apb_master_bridge_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SW = DW / 8
);
  // Request channel
  logic          req_vld;
  logic          req_rdy;
  logic          req_wen;
  logic [AW-1:0] req_adr;
  logic [SW-1:0] req_sel;
  logic [DW-1:0] req_dtw;

  // Response channel
  logic          rsp_vld;
  logic          rsp_rdy;
  logic [DW-1:0] rsp_dtr;
  logic          rsp_err;

  // APB signal set
  logic          pstrb;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [SW-1:0] psel;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  modport master (
    input  req_vld, req_wen, req_adr, req_sel, req_dtw,
    input  rsp_rdy,
    input  prdata, pready, pslverr,
    output req_rdy,
    output rsp_vld, rsp_dtr, rsp_err,
    output pstrb, penable, pwrite, paddr, psel, pwdata
  );

  modport slave (
    output req_vld, req_wen, req_adr, req_sel, req_dtw,
    output rsp_rdy,
    output prdata, pready, pslverr,
    input  req_rdy,
    input  rsp_vld, rsp_dtr, rsp_err,
    input  pstrb, penable, pwrite, paddr, psel, pwdata
  );
endinterface

// File: rtl/apb_master_bridge.sv
// Single-outstanding APB master: one valid/ready request becomes one SETUP/ACCESS
// sequence, with read data and error returned on a valid/ready response channel.
module apb_master_bridge #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SW = DW / 8,
  parameter int TO = 256
) (
  input  logic                  clk,
  input  logic                  rst,
  apb_master_bridge_if.master   bus
);

  localparam int CW = (TO > 0) ? $clog2(TO + 1) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_e;

  state_e        state_q,    state_d;
  logic          pstrb_q,    pstrb_d;
  logic          penable_q,  penable_d;
  logic          rsp_vld_q,  rsp_vld_d;
  logic          pwrite_q,   pwrite_d;
  logic [AW-1:0] paddr_q,    paddr_d;
  logic [SW-1:0] psel_q,     psel_d;
  logic [DW-1:0] pwdata_q,   pwdata_d;
  logic [DW-1:0] rsp_dtr_q,  rsp_dtr_d;
  logic          rsp_err_q,  rsp_err_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic          timeout;

  always_comb begin
    // NOTE: every _d gets its hold value first, so no path through the case can infer a latch.
    state_d    = state_q;
    pstrb_d    = pstrb_q;
    penable_d  = penable_q;
    rsp_vld_d  = rsp_vld_q;
    pwrite_d   = pwrite_q;
    paddr_d    = paddr_q;
    psel_d     = psel_q;
    pwdata_d   = pwdata_q;
    rsp_dtr_d  = rsp_dtr_q;
    rsp_err_d  = rsp_err_q;
    wait_cnt_d = wait_cnt_q;

    // The edge that would bring the wait count up to TO ends the access.
    timeout = 1'b0;
    if (TO > 0) begin
      timeout = (wait_cnt_q == CW'(TO - 1)) && !bus.pready;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_vld) begin
          state_d  = ST_SETUP;
          pstrb_d  = 1'b1;
          pwrite_d = bus.req_wen;
          paddr_d  = bus.req_adr;
          psel_d   = bus.req_sel;
          pwdata_d = bus.req_dtw;
        end
      end

      ST_SETUP: begin
        state_d    = ST_ACCESS;
        penable_d  = 1'b1;
        wait_cnt_d = '0;
      end

      ST_ACCESS: begin
        if (bus.pready) begin
          state_d   = ST_RESP;
          pstrb_d   = 1'b0;
          penable_d = 1'b0;
          rsp_vld_d = 1'b1;
          rsp_dtr_d = pwrite_q ? '0 : bus.prdata;
          rsp_err_d = bus.pslverr;
        end else if (timeout) begin
          state_d   = ST_RESP;
          pstrb_d   = 1'b0;
          penable_d = 1'b0;
          rsp_vld_d = 1'b1;
          rsp_dtr_d = '0;
          rsp_err_d = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end

      ST_RESP: begin
        if (bus.rsp_rdy) begin
          state_d   = ST_IDLE;
          rsp_vld_d = 1'b0;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update from the same pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pstrb_q    <= 1'b0;
      penable_q  <= 1'b0;
      rsp_vld_q  <= 1'b0;
      pwrite_q   <= 1'b0;
      paddr_q    <= '0;
      psel_q     <= '0;
      pwdata_q   <= '0;
      rsp_dtr_q  <= '0;
      rsp_err_q  <= 1'b0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      pstrb_q    <= pstrb_d;
      penable_q  <= penable_d;
      rsp_vld_q  <= rsp_vld_d;
      pwrite_q   <= pwrite_d;
      paddr_q    <= paddr_d;
      psel_q     <= psel_d;
      pwdata_q   <= pwdata_d;
      rsp_dtr_q  <= rsp_dtr_d;
      rsp_err_q  <= rsp_err_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end

  // Ready is low while reset is held and rises as soon as it is released.
  assign bus.req_rdy = (state_q == ST_IDLE) && !rst;
  assign bus.rsp_vld = rsp_vld_q;
  assign bus.rsp_dtr = rsp_dtr_q;
  assign bus.rsp_err = rsp_err_q;
  assign bus.pstrb   = pstrb_q;
  assign bus.penable = penable_q;
  assign bus.pwrite  = pwrite_q;
  assign bus.paddr   = paddr_q;
  assign bus.psel    = psel_q;
  assign bus.pwdata  = pwdata_q;

endmodule
